apu_issue_queue: RTL

//  Parametrised successor of the single-request APU handshake at the accelerator top level.

---
 rtl/accelerator_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 73 +++++++
 rtl/apu_issue_queue.sv | 126 ++++++++++++
 3 files changed

// File: rtl/accelerator_pkg.sv
`default_nettype none
// ============================================================================
// accelerator_pkg : shared types and constants for the accelerator top level
// Rev 1.0
// ============================================================================
package accelerator_pkg;

  localparam int APU_Q_DEPTH_DEFAULT = 4;
  localparam int APU_NUM_OPS         = 3;
  localparam int APU_OP_W            = 6;
  localparam int APU_FLAGS_IN_W      = 15;
  localparam int APU_FLAGS_OUT_W     = 5;

  // One buffered APU request in the default configuration.
  typedef struct packed {
    logic [APU_NUM_OPS*32-1:0]  operands;
    logic [APU_OP_W-1:0]        op;
    logic [APU_FLAGS_IN_W-1:0]  flags;
  } apu_req_t;

endpackage : accelerator_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : single-clock FIFO with registered full/empty and occupancy count
// Rev 1.0
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      // The head leaving this cycle is already consumed; everything else is dropped.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok) count_d = count_q + CW'(1);
      if (pop_ok && !push_ok) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/apu_issue_queue.sv
`default_nettype none
// ============================================================================
// apu_issue_queue : buffers core APU requests, issues them in order to the
//                   vector decoder and returns completions to the core
// Rev 1.0
// ============================================================================
module apu_issue_queue
  import accelerator_pkg::*;
#(
  parameter int DEPTH       = APU_Q_DEPTH_DEFAULT,
  parameter int NUM_OPS     = APU_NUM_OPS,
  parameter int OP_W        = APU_OP_W,
  parameter int FLAGS_IN_W  = APU_FLAGS_IN_W,
  parameter int FLAGS_OUT_W = APU_FLAGS_OUT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    apu_req,
  output logic                    apu_gnt,
  input  logic [NUM_OPS*32-1:0]   apu_operands_i,
  input  logic [OP_W-1:0]         apu_op,
  input  logic [FLAGS_IN_W-1:0]   apu_flags_i,
  output logic                    apu_rvalid,
  output logic [31:0]             apu_result,
  output logic [FLAGS_OUT_W-1:0]  apu_flags_o,
  output logic                    iss_valid,
  input  logic                    iss_ready,
  output logic [NUM_OPS*32-1:0]   iss_operands,
  output logic [OP_W-1:0]         iss_op,
  output logic [FLAGS_IN_W-1:0]   iss_flags,
  input  logic                    cpl_valid,
  input  logic [31:0]             cpl_result,
  input  logic [FLAGS_OUT_W-1:0]  cpl_flags,
  input  logic                    flush_i,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int CW = $clog2(DEPTH+1);

  // Same layout as apu_req_t, sized by this instance's parameters.
  typedef struct packed {
    logic [NUM_OPS*32-1:0]  operands;
    logic [OP_W-1:0]        op;
    logic [FLAGS_IN_W-1:0]  flags;
  } req_t;

  req_t                   push_req, head_req;
  logic                   fifo_full, fifo_empty;
  logic [CW-1:0]          fifo_count;
  logic                   accept, pop, cpl_ok;
  logic [CW-1:0]          outstanding_q, outstanding_d;
  logic [CW-1:0]          issued_q, issued_d;
  logic                   rvalid_q;
  logic [31:0]            result_q;
  logic [FLAGS_OUT_W-1:0] flags_q;
  logic                   err_q;

  assign push_req = '{operands: apu_operands_i, op: apu_op, flags: apu_flags_i};

  sync_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush_i),
    .push_i  (accept),
    .wdata_i (push_req),
    .pop_i   (pop),
    .rdata_o (head_req),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign apu_gnt = apu_req & ~fifo_full & (outstanding_q < CW'(DEPTH)) & ~flush_i & ~reset;
  assign accept  = apu_req & apu_gnt;

  assign iss_valid    = ~fifo_empty;
  assign iss_operands = head_req.operands;
  assign iss_op       = head_req.op;
  assign iss_flags    = head_req.flags;
  assign pop          = iss_valid & iss_ready;

  assign cpl_ok = cpl_valid & (issued_q != '0);

  always_comb begin
    outstanding_d = outstanding_q;
    issued_d      = issued_q;
    if (accept) outstanding_d = outstanding_d + CW'(1);
    if (cpl_ok) outstanding_d = outstanding_d - CW'(1);
    // Entries still queued after this cycle's pop will never return.
    if (flush_i) outstanding_d = outstanding_d - (fifo_count - CW'(pop));
    if (pop)    issued_d = issued_d + CW'(1);
    if (cpl_ok) issued_d = issued_d - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding_q <= '0;
      issued_q      <= '0;
      rvalid_q      <= 1'b0;
      result_q      <= '0;
      flags_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      issued_q      <= issued_d;
      rvalid_q      <= cpl_ok;
      if (cpl_ok) begin
        result_q <= cpl_result;
        flags_q  <= cpl_flags;
      end
      if (cpl_valid && issued_q == '0) err_q <= 1'b1;
    end
  end

  assign apu_rvalid  = rvalid_q;
  assign apu_result  = result_q;
  assign apu_flags_o = flags_q;
  assign busy_o      = (outstanding_q != '0);
  assign err_o       = err_q;

endmodule : apu_issue_queue
`default_nettype wire
